// File: rtl/alu_issue.sv
// Decode/issue stage feeding a multi-cycle ALU: register file, operand issue, writeback, flags.
// Optional: define ALU_ISSUE_R0_ZERO_EN to hard-wire R0 to zero.
module alu_issue #(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic              alu_incoming,
    output logic [3:0]        alu_operator,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_carry,
    input  logic              alu_signov,
    input  logic              alu_done,
    output logic              flag_c,
    output logic              flag_v,
    output logic              busy,
    output logic              err_illegal,
    output logic              err_timeout,
    input  logic              err_clr,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [REG_CNT];
    logic [3:0]        rd_q;
    logic              ldi_q;
    logic [DATA_W-1:0] y_q;
    logic              c_q;
    logic              v_q;
    logic [7:0]        cnt;

    logic [3:0] op;
    logic       op_illegal;
    logic       op_ldi;
    logic       wr_ok;

    assign op         = instr[15:12];
    assign op_illegal = (op == 4'd6) || (op == 4'd13) || (op == 4'd14);
    assign op_ldi     = (op == 4'd15);

    function automatic logic [DATA_W-1:0] rd_reg(input logic [3:0] addr);
`ifdef ALU_ISSUE_R0_ZERO_EN
        rd_reg = (addr == 4'd0) ? '0 : regs[addr];
`else
        rd_reg = regs[addr];
`endif
    endfunction

`ifdef ALU_ISSUE_R0_ZERO_EN
    assign wr_ok = (rd_q != 4'd0);
`else
    assign wr_ok = 1'b1;
`endif

    assign dbg_data = rd_reg(dbg_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            instr_ready  <= 1'b1;
            alu_incoming <= 1'b0;
            alu_operator <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            flag_c       <= 1'b0;
            flag_v       <= 1'b0;
            busy         <= 1'b0;
            err_illegal  <= 1'b0;
            err_timeout  <= 1'b0;
            rd_q         <= '0;
            ldi_q        <= 1'b0;
            y_q          <= '0;
            c_q          <= 1'b0;
            v_q          <= 1'b0;
            cnt          <= '0;
            for (int unsigned i = 0; i < REG_CNT; i++) regs[i] <= '0;
        end else begin
            alu_incoming <= 1'b0;
            // Clear first so a same-cycle error set below takes precedence.
            if (err_clr) begin
                err_illegal <= 1'b0;
                err_timeout <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        rd_q <= instr[11:8];
                        if (op_illegal) begin
                            err_illegal <= 1'b1;
                        end else if (op_ldi) begin
                            ldi_q       <= 1'b1;
                            y_q         <= DATA_W'(instr[7:0]);
                            state       <= S_WB;
                            instr_ready <= 1'b0;
                            busy        <= 1'b1;
                        end else begin
                            ldi_q        <= 1'b0;
                            alu_operator <= op;
                            alu_a        <= rd_reg(instr[7:4]);
                            alu_b        <= rd_reg(instr[3:0]);
                            alu_incoming <= 1'b1;
                            state        <= S_ISSUE;
                            instr_ready  <= 1'b0;
                            busy         <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_done) begin
                        y_q   <= alu_y;
                        c_q   <= alu_carry;
                        v_q   <= alu_signov;
                        state <= S_WB;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_WB: begin
                    if (wr_ok) regs[rd_q] <= y_q;
                    if (!ldi_q) begin
                        flag_c <= c_q;
                        flag_v <= v_q;
                    end
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
